// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and default widths for the two-port RAM arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;
    localparam int   ADDR_W     = 4;
    localparam int   DATA_W     = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshake plus RAM-side bus of the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        ack;
    logic [DATA_W-1:0] rdata;
    logic              ram_read, ram_write;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  ack, rdata, ram_read, ram_write, ram_addr, ram_wdata
    );
    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, ram_rdata,
        output ack, rdata, ram_read, ram_write, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker; on a tie the port other than last wins.
module rr_arb2 (
    input  logic [1:0] eligible_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);
    assign valid_o  = |eligible_i;
    assign winner_o = (&eligible_i) ? ~last_i : eligible_i[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port RAM between fetch and data requesters,
// one registered access at a time with a one-cycle ack and captured read data.
module mem_arbiter #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    import mem_arb_pkg::*;

    state_e            state_q, state_d;
    logic              sel_q, sel_d, last_q, last_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [1:0]        ack_q, ack_d, elig;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              valid, winner;

    // The port being acked in DONE still holds its finished request, so hide it.
    assign elig = bus.req & ((state_q == DONE) ? ~ack_q : 2'b11);

    rr_arb2 u_arb (
        .eligible_i(elig),
        .last_i    (last_q),
        .valid_o   (valid),
        .winner_o  (winner)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ack_d   = 2'b00;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q == ACCESS) begin
            state_d = DONE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            ack_d   = (sel_q == PORT_DATA) ? 2'b10 : 2'b01;
            last_d  = sel_q;
            rdata_d = rd_q ? bus.ram_rdata : rdata_q;
        end else if (valid) begin
            state_d = ACCESS;
            sel_d   = winner;
            addr_d  = (winner == PORT_DATA) ? bus.addr1 : bus.addr0;
            wdata_d = (winner == PORT_DATA) ? bus.wdata1 : bus.wdata0;
            rd_d    = ~bus.we[winner];
            wr_d    = bus.we[winner];
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= PORT_FETCH;
            last_q  <= PORT_DATA;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ack_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_read  = rd_q;
    assign bus.ram_write = wr_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the 16x8 single-port data/instruction RAM. It shares the RAM between the instruction-fetch requester (port 0) and the execute/data requester (port 1) using round-robin selection. It drives the RAM's read/write strobes, address and write data from registers, so the RAM never sees both strobes at once. Read data is captured into a register and returned with a one-cycle acknowledge pulse.

## Interface
Parameters:
- ADDR_W, 4, RAM address width (16 locations)
- DATA_W, 8, RAM word width

Ports:
- clk  in  1  single system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  per-port request; bit0 = fetch, bit1 = data
- we  in  2  per-port write-enable; 1 = write, 0 = read; sampled with req
- addr0, addr1  in  ADDR_W  per-port address
- wdata0, wdata1  in  DATA_W  per-port write data
- ack  out  2  one-cycle completion pulse to the served port
- rdata  out  DATA_W  registered read data; valid when ack is high for a read
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM data_in
- ram_rdata  in  DATA_W  RAM data_out (combinational from RAM)

## Operation
- States: IDLE, ACCESS, DONE. Registered: state, grant index `sel`, last-served pointer `last`, all ram_* outputs, ack, rdata.
- Arbitration happens in IDLE and DONE. Eligible set = req, except that in DONE the port being acked is masked.
  - If both ports are eligible, the port != last wins.
  - If one port is eligible, it wins.
  - If none is eligible, go to (or stay in) IDLE.
- On a win: register sel and copy the winner's addr/wdata into ram_addr/ram_wdata. Set ram_read = ~we[sel] and ram_write = we[sel]. Go to ACCESS.
- ACCESS: strobes held for exactly one cycle. At the end of the cycle, rdata <= ram_rdata if reading; rdata holds its previous value on writes. Strobes are cleared, ack[sel] <= 1, last <= sel, and the state goes to DONE.
- DONE: ack high for this cycle only. Re-arbitrate, giving ACCESS on a win or IDLE otherwise.
- ram_read and ram_write are never high together. Both are low outside ACCESS.
- A requester holds req/we/addr/wdata stable from assertion until it sees ack. It drops req in the cycle after ack or starts a new request; a masked port is reconsidered in the following arbitration.
- Reset (async, any state): state = IDLE; ack = 0; rdata = 0; ram_read = ram_write = 0; ram_addr = 0; ram_wdata = 0; sel = 0; last = 1, so port 0 wins the first tie.
  - Reset during ACCESS aborts the access: strobes drop immediately and no ack is issued.

## Timing
- Read/write latency: req seen high at edge N (state IDLE) → ACCESS in cycle N+1 → ack/rdata valid in cycle N+2.
- Throughput: one access per 2 cycles when the two ports alternate (DONE→ACCESS). The same port back-to-back takes 3 cycles (one IDLE gap).
- Both ports requesting continuously: grants strictly alternate 0,1,0,1… starting with the port != last.
- Simultaneous first request after reset: port 0 first.
- Address wrap: none. ADDR_W bits are passed through unchanged; address 15 is a normal location.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE}
  - port index constants PORT_FETCH = 0, PORT_DATA = 1
  - defaults ADDR_W/DATA_W
- One natural sub-module: rr_arb2 (combinational 2-way round-robin picker).
  - Inputs: eligible[1:0], last.
  - Outputs: valid, winner.
- FSM, output registers and rdata capture live in mem_arbiter.

## Test plan
- Reset then port0 read addr 0 (RAM holds 0x0C) → ram_read high for exactly cycle N+1; ack = 01 and rdata = 0x0C at N+2; ram_write never high.
- Port1 write addr 5 with 0xA5, then port0 read addr 5 → write strobe for one cycle with ram_wdata = 0xA5; read returns 0xA5; ack order 10 then 01.
- Both ports read continuously (addr0 = 2 → 0x26, addr1 = 10 → 0x1B) → acks alternate 01,10,01,10 every 2 cycles; rdata matches per grant.
- Port0 alone re-requests immediately after ack → IDLE gap observed; second ack 3 cycles after the first; no duplicate ack for the held request.
- rst_n low mid-ACCESS on a write → strobes drop asynchronously; no ack; after release the first tie goes to port 0.
- Random req/we/addr over 2000 cycles against a RAM model:
  - never both strobes high;
  - one ack per request;
  - rdata always equals the model contents.
